uart_pg_loader: RTL and testbench

- Master end of the program-download interface. Consumes a byte stream from the UART receiver, frames it into 16-bit words, and drives pg_wen/pg_din/pg_adr into the BIOS RAM.
- Asserts pg_done once a complete, valid image has been written. pg_done hands the RAM port over to the Wishbone/CPU side.
- Sits between uart_rx and the BIOS RAM block, in the pg_clk_i domain.

---
 rtl/uart_pg_loader.sv | 154 +++++++++++++++
 tb/tb_uart_pg_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pg_loader.sv
// Purpose : frames the UART byte stream into 16-bit words and writes them into the BIOS RAM.
// Latency : the RAM write is registered one cycle after the high data byte is accepted.
// Backpress: none; bytes are taken whenever rx_valid_i pulses, and there is no ready signal.
//
// Ports:
//   pg_clk_i, pg_rstn_i   program clock and asynchronous active-low reset
//   rx_data_i, rx_valid_i byte stream from uart_rx, as a one-cycle strobe
//   pg_wen/pg_din/pg_adr  RAM write strobe, data {hi, lo} and word address
//   pg_done               image loaded; sticky until reset; hands the RAM to the CPU side
//   pg_err                frame error (timeout or checksum); cleared by the next SYNC byte
//   pg_busy               a frame is in progress
// Build option: define PG_CHECKSUM_EN to add the trailing XOR checksum byte and its check.
module uart_pg_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [15:0] ADR_BASE       = 16'h0000,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        pg_clk_i,
  input  logic        pg_rstn_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        pg_wen,
  output logic [15:0] pg_din,
  output logic [15:0] pg_adr,
  output logic        pg_done,
  output logic        pg_err,
  output logic        pg_busy
);

`ifdef PG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_L, S_LEN_H, S_DAT_L, S_DAT_H, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_L, S_LEN_H, S_DAT_L, S_DAT_H, S_DONE, S_ERR
  } state_t;
`endif

  state_t      state;
  logic [15:0] len;
  logic [7:0]  lo_byte;
  logic [15:0] index;
  logic [23:0] tmo_cnt;
`ifdef PG_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_ff @(posedge pg_clk_i or negedge pg_rstn_i) begin
    if (!pg_rstn_i) begin
      state   <= S_IDLE;
      len     <= '0;
      lo_byte <= '0;
      index   <= '0;
      tmo_cnt <= '0;
`ifdef PG_CHECKSUM_EN
      csum    <= '0;
`endif
      pg_wen  <= 1'b0;
      pg_din  <= '0;
      pg_adr  <= '0;
      pg_done <= 1'b0;
      pg_err  <= 1'b0;
      pg_busy <= 1'b0;
    end else begin
      pg_wen <= 1'b0;
      case (state)
        S_IDLE, S_ERR: begin
          // Only a SYNC byte opens a frame; re-sync from ERR starts over at index 0.
          if (rx_valid_i && rx_data_i == SYNC_BYTE) begin
            state   <= S_LEN_L;
            pg_err  <= 1'b0;
            pg_busy <= 1'b1;
            index   <= '0;
            tmo_cnt <= '0;
`ifdef PG_CHECKSUM_EN
            csum    <= '0;
`endif
          end
        end
        // pg_done follows DONE by one cycle so the last write lands before the RAM mux flips.
        S_DONE: pg_done <= 1'b1;
        default: begin
          if (rx_valid_i) begin
            tmo_cnt <= '0;
`ifdef PG_CHECKSUM_EN
            if (state != S_CHK) csum <= csum ^ rx_data_i;
`endif
            case (state)
              S_LEN_L: begin
                len[7:0] <= rx_data_i;
                state    <= S_LEN_H;
              end
              S_LEN_H: begin
                len[15:8] <= rx_data_i;
                if ({rx_data_i, len[7:0]} == 16'd0) begin
`ifdef PG_CHECKSUM_EN
                  state <= S_CHK;
`else
                  state   <= S_DONE;
                  pg_busy <= 1'b0;
`endif
                end else begin
                  state <= S_DAT_L;
                end
              end
              S_DAT_L: begin
                lo_byte <= rx_data_i;
                state   <= S_DAT_H;
              end
              S_DAT_H: begin
                pg_wen <= 1'b1;
                pg_din <= {rx_data_i, lo_byte};
                pg_adr <= ADR_BASE + index;  // wraps modulo 2^16
                index  <= index + 16'd1;
                if (index == len - 16'd1) begin
`ifdef PG_CHECKSUM_EN
                  state <= S_CHK;
`else
                  state   <= S_DONE;
                  pg_busy <= 1'b0;
`endif
                end else begin
                  state <= S_DAT_L;
                end
              end
`ifdef PG_CHECKSUM_EN
              S_CHK: begin
                pg_busy <= 1'b0;
                if (rx_data_i == csum) begin
                  state   <= S_DONE;
                  pg_done <= 1'b1;
                end else begin
                  state  <= S_ERR;
                  pg_err <= 1'b1;
                end
              end
`endif
              default: ;
            endcase
          end else if (tmo_cnt == TIMEOUT_CYCLES - 24'd1) begin
            // Words already written stay in RAM; only the frame is abandoned.
            state   <= S_ERR;
            pg_err  <= 1'b1;
            pg_busy <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + 24'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pg_loader.sv
// Purpose : randomized plus directed scoreboard bench for uart_pg_loader.
// Latency : expected writes are due one cycle after the high byte; pg_done timing is checked exactly.
// Backpress: none; one byte stream drives two loaders, at ADR_BASE 0000 and at FFFF.
module tb_uart_pg_loader;

  localparam int TMO = 100;
`ifdef PG_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        wen0, done0, err0, busy0, wen1, done1, err1, busy1;
  logic [15:0] din0, adr0, din1, adr1;

  uart_pg_loader #(.ADR_BASE(16'h0000), .TIMEOUT_CYCLES(24'(TMO))) dut0 (
    .pg_clk_i(clk), .pg_rstn_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .pg_wen(wen0), .pg_din(din0), .pg_adr(adr0), .pg_done(done0), .pg_err(err0), .pg_busy(busy0));

  uart_pg_loader #(.ADR_BASE(16'hFFFF), .TIMEOUT_CYCLES(24'(TMO))) dut1 (
    .pg_clk_i(clk), .pg_rstn_i(rst_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .pg_wen(wen1), .pg_din(din1), .pg_adr(adr1), .pg_done(done1), .pg_err(err1), .pg_busy(busy1));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] adr;
    logic [15:0] din;
    int          at;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];
  int  checks = 0;
  int  passes = 0;
  int  exp_done_at = -1;  // -1: no rise allowed, -2: rise at any cycle, else exact cycle
  int  last_t = 0;
  logic prev_done0 = 1'b0, prev_done1 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard whenever a loader presents a write, and watches pg_done rises.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (wen0) begin
        if (q0.size() == 0) check("wen0_unexpected", wen0, 1'b0);
        else begin
          e = q0.pop_front();
          check("wr0_adr", adr0, e.adr);
          check("wr0_din", din0, e.din);
          check("wr0_cycle", cyc, e.at);
        end
      end
      if (wen1) begin
        if (q1.size() == 0) check("wen1_unexpected", wen1, 1'b0);
        else begin
          e = q1.pop_front();
          check("wr1_adr", adr1, e.adr);
          check("wr1_din", din1, e.din);
          check("wr1_cycle", cyc, e.at);
        end
      end
      if (done0 && !prev_done0) begin
        if (exp_done_at >= 0) check("done0_cycle", cyc, exp_done_at);
        else if (exp_done_at == -1) check("done0_unexpected", done0, 1'b0);
      end
      if (done1 && !prev_done1) begin
        if (exp_done_at >= 0) check("done1_cycle", cyc, exp_done_at);
        else if (exp_done_at == -1) check("done1_unexpected", done1, 1'b0);
      end
      prev_done0 = done0;
      prev_done1 = done1;
    end
  end

  // Stimulus runs at negedges; drive() presents a byte, tick() lets the next posedge take it.
  task automatic drive(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_t   = cyc;
  endtask

  task automatic tick();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    drive(b);
    tick();
    repeat (gap) @(negedge clk);
  endtask

  task automatic expect_write(input int i, input logic [15:0] w);
    q0.push_back('{16'h0000 + 16'(i), w, last_t + 1});
    q1.push_back('{16'hFFFF + 16'(i), w, last_t + 1});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wen0"}, wen0, 1'b0);   check({tag, "_wen1"}, wen1, 1'b0);
    check({tag, "_din0"}, din0, 16'h0);  check({tag, "_adr1"}, adr1, 16'h0);
    check({tag, "_adr0"}, adr0, 16'h0);  check({tag, "_din1"}, din1, 16'h0);
    check({tag, "_done0"}, done0, 1'b0); check({tag, "_err0"}, err0, 1'b0);
    check({tag, "_busy0"}, busy0, 1'b0); check({tag, "_busy1"}, busy1, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    exp_done_at = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference frame: writes land at base+i in order; the checksum is the XOR of length and data bytes.
  task automatic send_frame(input logic [15:0] words[$], input int max_gap, input bit bad_chk);
    logic [7:0]  x;
    logic [15:0] n;
    n = 16'(words.size());
    send(8'hA5, $urandom_range(max_gap, 0));
    check("sync_clears_err0", err0, 1'b0);
    check("sync_sets_busy1", busy1, 1'b1);
    send(n[7:0], $urandom_range(max_gap, 0));
    if (!CHK_EN && n == 16'd0) exp_done_at = -2;
    drive(n[15:8]);
    tick();
    repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    x = n[7:0] ^ n[15:8];
    for (int i = 0; i < words.size(); i++) begin
      send(words[i][7:0], $urandom_range(max_gap, 0));
      drive(words[i][15:8]);
      expect_write(i, words[i]);
      if (!CHK_EN && i == words.size() - 1) exp_done_at = last_t + 2;
      tick();
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
      x = x ^ words[i][7:0] ^ words[i][15:8];
    end
    if (CHK_EN) begin
      drive(bad_chk ? (x ^ 8'h01) : x);
      if (!bad_chk) exp_done_at = last_t + 1;
      tick();
    end
  endtask

  task automatic end_check(input string tag, input bit done_e, input bit err_e);
    repeat (3) @(negedge clk);
    check({tag, "_q0_left"}, q0.size(), 0);
    check({tag, "_q1_left"}, q1.size(), 0);
    check({tag, "_done0"}, done0, done_e);
    check({tag, "_done1"}, done1, done_e);
    check({tag, "_err0"}, err0, err_e);
    check({tag, "_err1"}, err1, err_e);
    check({tag, "_busy0"}, busy0, 1'b0);
  endtask

  initial begin
    logic [15:0] words[$];
    logic [15:0] w;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed two-word image.
    words = '{16'h1234, 16'h5678};
    send_frame(words, 0, 1'b0);
    end_check("two_words", 1'b1, 1'b0);

    // Leading junk ignored; SYNC value inside the frame is data.
    do_reset();
    send(8'h00, 0);
    send(8'hFF, 1);
    words = '{16'hA5A5};
    send_frame(words, 1, 1'b0);
    end_check("junk_and_a5", 1'b1, 1'b0);

    // Timeout after one word of a three-word frame, then recovery.
    do_reset();
    send(8'hA5, 0); send(8'h03, 0); send(8'h00, 0); send(8'h11, 0);
    drive(8'h22);
    expect_write(0, 16'h2211);
    tick();
    repeat (TMO - 2) @(negedge clk);
    check("tmo_err_early", err0, 1'b0);
    check("tmo_busy_early", busy0, 1'b1);
    repeat (3) @(negedge clk);
    check("tmo_err0", err0, 1'b1);
    check("tmo_err1", err1, 1'b1);
    check("tmo_busy", busy0, 1'b0);
    check("tmo_q0_left", q0.size(), 0);
    words = '{16'hC0DE};
    send_frame(words, 2, 1'b0);
    end_check("after_tmo", 1'b1, 1'b0);

    // Asynchronous reset between LO and HI of word 1.
    do_reset();
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0); send(8'h34, 0);
    drive(8'h12);
    expect_write(0, 16'h1234);
    tick();
    send(8'h78, 0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midframe_rst");
    drive(8'h56);
    tick();
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_done_at = -1;
    @(negedge clk);
    words = '{16'hAB01, 16'hCD02, 16'hEF03};
    send_frame(words, 1, 1'b0);
    end_check("after_rst", 1'b1, 1'b0);

    // Bytes after DONE are ignored.
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h77, 0); send(8'h66, 0);
    end_check("after_done", 1'b1, 1'b0);

    if (CHK_EN) begin
      do_reset();
      words = '{16'hBEEF};
      send_frame(words, 0, 1'b1);
      end_check("bad_chk", 1'b0, 1'b1);
    end

    // Randomized frames.
    for (int it = 0; it < 12; it++) begin
      do_reset();
      repeat ($urandom_range(3, 0)) send(8'($urandom_range(8'hA4, 0)), $urandom_range(2, 0));
      words.delete();
      repeat ($urandom_range(5, 0)) begin
        w = 16'($urandom);
        if ($urandom_range(3, 0) == 0) w[7:0] = 8'hA5;
        words.push_back(w);
      end
      send_frame(words, 3, 1'b0);
      end_check("rand", 1'b1, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #300_000;
    $display("FAIL watchdog: bench stuck at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
